// File: rtl/bj_pkg.sv
// Shared definitions for the blackjack round sequencer: state and result
// encodings, card rank constants and the card value helpers.
// Optional build macro used by blackjack_game_ctrl: DEALER_HIT_SOFT17_EN.
package bj_pkg;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    DEAL_P1     = 4'd1,
    DEAL_D1     = 4'd2,
    DEAL_P2     = 4'd3,
    DEAL_D2     = 4'd4,
    PLAYER_TURN = 4'd5,
    PLAYER_DRAW = 4'd6,
    DEALER_TURN = 4'd7,
    DEALER_DRAW = 4'd8,
    RESOLVE     = 4'd9,
    DONE        = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_WIN  = 2'd1,
    RES_LOSE = 2'd2,
    RES_PUSH = 2'd3
  } result_t;

  localparam logic [3:0] RANK_ACE   = 4'd1;
  localparam logic [3:0] RANK_KING  = 4'd13;
  localparam logic [5:0] BLACKJACK  = 6'd21;
  localparam logic [5:0] SOFT_BONUS = 6'd10;

  // Ace counts 1 here; the soft bonus is applied by the accumulator.
  function automatic logic [5:0] cardValue(input logic [3:0] rank);
    if (rank >= 4'd10) return 6'd10;
    return {2'b00, rank};
  endfunction

  function automatic logic rankValid(input logic [3:0] rank);
    return (rank >= RANK_ACE) && (rank <= RANK_KING);
  endfunction

endpackage

// File: rtl/bj_hand_accum.sv
// One blackjack hand: hard sum, ace flag and card count, with the best
// score and soft flag registered alongside so they are valid the cycle
// after a card is added.
module bj_hand_accum
  import bj_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_add,
  input  logic [3:0] i_rank,
  output logic [5:0] o_score,
  output logic       o_soft,
  output logic [2:0] o_count
);

  logic [5:0] r_hard;
  logic       r_ace;
  logic [2:0] r_count;
  logic [5:0] r_score;
  logic       r_soft;

  logic [5:0] w_nextHard;
  logic       w_nextAce;
  logic [2:0] w_nextCount;
  logic       w_nextSoft;
  logic [5:0] w_nextScore;

  // Next hand contents; the score is derived from the post-add values.
  always_comb begin
    w_nextHard  = r_hard;
    w_nextAce   = r_ace;
    w_nextCount = r_count;
    if (i_clear) begin
      w_nextHard  = 6'd0;
      w_nextAce   = 1'b0;
      w_nextCount = 3'd0;
    end else if (i_add) begin
      w_nextHard  = r_hard + cardValue(i_rank);
      w_nextAce   = r_ace | (i_rank == RANK_ACE);
      w_nextCount = r_count + 3'd1;
    end
    w_nextSoft  = w_nextAce && (w_nextHard <= (BLACKJACK - SOFT_BONUS));
    w_nextScore = w_nextSoft ? (w_nextHard + SOFT_BONUS) : w_nextHard;
  end

  // Hand state registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_hard  <= 6'd0;
      r_ace   <= 1'b0;
      r_count <= 3'd0;
      r_score <= 6'd0;
      r_soft  <= 1'b0;
    end else begin
      r_hard  <= w_nextHard;
      r_ace   <= w_nextAce;
      r_count <= w_nextCount;
      r_score <= w_nextScore;
      r_soft  <= w_nextSoft;
    end
  end

  assign o_score = r_score;
  assign o_soft  = r_soft;
  assign o_count = r_count;

endmodule

// File: rtl/blackjack_game_ctrl.sv
// Blackjack round sequencer: deal, player turn, dealer turn, resolve.
// Every draw state requests a card, takes it on a valid ack, then spends
// one cycle with card_req low so the registered hand score settles before
// the next decision. Define DEALER_HIT_SOFT17_EN to make the dealer draw
// on a soft 17.
module blackjack_game_ctrl
  import bj_pkg::*;
#(
  parameter int DEALER_STAND = 17,
  parameter int MAX_CARDS    = 7
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       hit_pressed,
  input  logic       stand_pressed,
  input  logic       deal_pressed,
  output logic       card_req,
  input  logic       card_ack,
  input  logic [3:0] card_rank,
  output logic [5:0] player_score,
  output logic [5:0] dealer_score,
  output logic [2:0] player_cards,
  output logic [2:0] dealer_cards,
  output logic [3:0] game_state,
  output logic [1:0] result,
  output logic       round_done
);

  localparam logic [5:0] STAND_LIMIT = 6'(DEALER_STAND);
  localparam logic [2:0] CARD_CAP    = 3'(MAX_CARDS);

  state_t  r_state;
  state_t  w_nextState;
  logic    r_gotCard;
  logic    w_nextGot;
  result_t r_result;
  result_t w_nextResult;

  logic w_clear;
  logic w_drawState;
  logic w_validAck;
  logic w_addPlayer;
  logic w_addDealer;
  logic w_dealerDraws;
  logic w_playerSoftUnused;
`ifdef DEALER_HIT_SOFT17_EN
  logic w_dealerSoft;
`else
  logic w_dealerSoftUnused;
`endif

  bj_hand_accum u_player (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .i_clear  (w_clear),
    .i_add    (w_addPlayer),
    .i_rank   (card_rank),
    .o_score  (player_score),
    .o_soft   (w_playerSoftUnused),
    .o_count  (player_cards)
  );

  bj_hand_accum u_dealer (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .i_clear  (w_clear),
    .i_add    (w_addDealer),
    .i_rank   (card_rank),
    .o_score  (dealer_score),
`ifdef DEALER_HIT_SOFT17_EN
    .o_soft   (w_dealerSoft),
`else
    .o_soft   (w_dealerSoftUnused),
`endif
    .o_count  (dealer_cards)
  );

  assign w_drawState = (r_state == DEAL_P1) || (r_state == DEAL_D1) ||
                       (r_state == DEAL_P2) || (r_state == DEAL_D2) ||
                       (r_state == PLAYER_DRAW) || (r_state == DEALER_DRAW);
  // Gated by reset so the request drops as soon as reset is sampled.
  assign card_req    = w_drawState && !r_gotCard && !reset;
  assign w_validAck  = card_req && card_ack && rankValid(card_rank);
  assign w_addPlayer = w_validAck && ((r_state == DEAL_P1) ||
                       (r_state == DEAL_P2) || (r_state == PLAYER_DRAW));
  assign w_addDealer = w_validAck && ((r_state == DEAL_D1) ||
                       (r_state == DEAL_D2) || (r_state == DEALER_DRAW));

`ifdef DEALER_HIT_SOFT17_EN
  assign w_dealerDraws = (dealer_cards < CARD_CAP) &&
                         ((dealer_score < STAND_LIMIT) ||
                          ((dealer_score == STAND_LIMIT) && w_dealerSoft));
`else
  assign w_dealerDraws = (dealer_cards < CARD_CAP) && (dealer_score < STAND_LIMIT);
`endif

  // Next-state, handshake phase and result decisions.
  always_comb begin
    w_nextState  = r_state;
    w_nextGot    = r_gotCard;
    w_nextResult = r_result;
    w_clear      = 1'b0;
    if (w_drawState) begin
      if (!r_gotCard) begin
        w_nextGot = w_validAck;
      end else begin
        w_nextGot = 1'b0;
        case (r_state)
          DEAL_P1:     w_nextState = DEAL_D1;
          DEAL_D1:     w_nextState = DEAL_P2;
          DEAL_P2:     w_nextState = DEAL_D2;
          DEAL_D2:     w_nextState = PLAYER_TURN;
          DEALER_DRAW: w_nextState = DEALER_TURN;
          default: begin
            if (player_score > BLACKJACK)       w_nextState = RESOLVE;
            else if (player_score == BLACKJACK) w_nextState = DEALER_TURN;
            else                                w_nextState = PLAYER_TURN;
          end
        endcase
      end
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (deal_pressed) begin
            w_clear      = 1'b1;
            w_nextResult = RES_NONE;
            w_nextState  = DEAL_P1;
          end
        end
        PLAYER_TURN: begin
          if ((player_score == BLACKJACK) && (player_cards == 3'd2))
            w_nextState = DEALER_TURN;
          else if (stand_pressed)
            w_nextState = DEALER_TURN;
          else if (hit_pressed && (player_cards < CARD_CAP))
            w_nextState = PLAYER_DRAW;
        end
        DEALER_TURN: begin
          w_nextState = w_dealerDraws ? DEALER_DRAW : RESOLVE;
        end
        RESOLVE: begin
          if (player_score > BLACKJACK)         w_nextResult = RES_LOSE;
          else if (dealer_score > BLACKJACK)    w_nextResult = RES_WIN;
          else if (player_score > dealer_score) w_nextResult = RES_WIN;
          else if (player_score < dealer_score) w_nextResult = RES_LOSE;
          else                                  w_nextResult = RES_PUSH;
          w_nextState = DONE;
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  // State, handshake phase and result registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state   <= IDLE;
      r_gotCard <= 1'b0;
      r_result  <= RES_NONE;
    end else begin
      r_state   <= w_nextState;
      r_gotCard <= w_nextGot;
      r_result  <= w_nextResult;
    end
  end

  assign game_state = r_state;
  assign result     = r_result;
  assign round_done = (r_state == DONE);

endmodule

// File: tb/tb_blackjack_game_ctrl.sv
// Directed self-checking bench for blackjack_game_ctrl. Expectations for
// the soft-17 round follow DEALER_HIT_SOFT17_EN when it is defined.
module tb_blackjack_game_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       hit_pressed = 1'b0;
  logic       stand_pressed = 1'b0;
  logic       deal_pressed = 1'b0;
  logic       card_req;
  logic       card_ack = 1'b0;
  logic [3:0] card_rank = 4'd0;
  logic [5:0] player_score;
  logic [5:0] dealer_score;
  logic [2:0] player_cards;
  logic [2:0] dealer_cards;
  logic [3:0] game_state;
  logic [1:0] result;
  logic       round_done;

  int total = 0;
  int bad   = 0;

  blackjack_game_ctrl dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .hit_pressed   (hit_pressed),
    .stand_pressed (stand_pressed),
    .deal_pressed  (deal_pressed),
    .card_req      (card_req),
    .card_ack      (card_ack),
    .card_rank     (card_rank),
    .player_score  (player_score),
    .dealer_score  (dealer_score),
    .player_cards  (player_cards),
    .dealer_cards  (dealer_cards),
    .game_state    (game_state),
    .result        (result),
    .round_done    (round_done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Hard stop in case the sequence itself stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One-cycle pulse on the selected buttons.
  task automatic applyStimulus(input logic hit, input logic stand, input logic deal);
    hit_pressed   = hit;
    stand_pressed = stand;
    deal_pressed  = deal;
    tick();
    hit_pressed   = 1'b0;
    stand_pressed = 1'b0;
    deal_pressed  = 1'b0;
  endtask

  task automatic waitState(input logic [3:0] target, input string tag);
    int n = 0;
    while (game_state !== target && n < 50) begin
      tick();
      n++;
    end
    checkOutput(tag, game_state, target);
  endtask

  // Serve one card: wait for the request, ack it, expect the request to
  // drop, then let the settle cycle pass.
  task automatic drawCard(input logic [3:0] rank, input string tag);
    int n = 0;
    while (card_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checkOutput({tag, "_req"}, card_req, 1);
    card_ack  = 1'b1;
    card_rank = rank;
    tick();
    card_ack  = 1'b0;
    card_rank = 4'd0;
    checkOutput({tag, "_reqlow"}, card_req, 0);
    tick();
  endtask

  initial begin
    $display("[TB] start");
    tick();
    tick();
    checkOutput("rst_state", game_state, 0);
    checkOutput("rst_req", card_req, 0);
    checkOutput("rst_pscore", player_score, 0);
    checkOutput("rst_dscore", dealer_score, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_done", round_done, 0);
    reset = 1'b0;
    tick();

    // Round 1: player blackjack auto-stands, dealer 14 draws 3 to 17.
    applyStimulus(0, 0, 1);
    checkOutput("r1_dealp1", game_state, 1);
    drawCard(4'd10, "r1_p1");
    drawCard(4'd9,  "r1_d1");
    drawCard(4'd1,  "r1_p2");
    drawCard(4'd5,  "r1_d2");
    checkOutput("r1_pturn", game_state, 5);
    checkOutput("r1_pscore", player_score, 21);
    checkOutput("r1_dscore14", dealer_score, 14);
    tick();
    checkOutput("r1_autostand", game_state, 7);
    drawCard(4'd3, "r1_d3");
    waitState(4'd10, "r1_done_state");
    checkOutput("r1_result", result, 1);
    checkOutput("r1_round_done", round_done, 1);
    checkOutput("r1_pcards", player_cards, 2);
    checkOutput("r1_dcards", dealer_cards, 3);
    checkOutput("r1_dscore", dealer_score, 17);

    // Round 2: player 16 hits a king and busts; dealer never draws.
    applyStimulus(0, 0, 1);
    checkOutput("r2_clear_result", result, 0);
    checkOutput("r2_clear_pcards", player_cards, 0);
    drawCard(4'd10, "r2_p1");
    drawCard(4'd9,  "r2_d1");
    drawCard(4'd6,  "r2_p2");
    drawCard(4'd8,  "r2_d2");
    checkOutput("r2_pturn", game_state, 5);
    applyStimulus(1, 0, 0);
    checkOutput("r2_pdraw", game_state, 6);
    drawCard(4'd13, "r2_hit");
    checkOutput("r2_resolve", game_state, 9);
    checkOutput("r2_pscore", player_score, 26);
    tick();
    checkOutput("r2_done", game_state, 10);
    checkOutput("r2_result", result, 2);
    tick();
    checkOutput("r2_noreq", card_req, 0);
    checkOutput("r2_dcards", dealer_cards, 2);

    // Buttons outside the player turn are ignored.
    applyStimulus(1, 1, 0);
    checkOutput("r2_ignore_hit", game_state, 10);

    // Round 3: slow card source with an invalid rank before the real card.
    applyStimulus(0, 0, 1);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("r3_req_wait", card_req, 1);
    card_ack  = 1'b1;
    card_rank = 4'd0;
    tick();
    card_ack  = 1'b0;
    checkOutput("r3_req_after_bad", card_req, 1);
    checkOutput("r3_pcards_bad", player_cards, 0);
    drawCard(4'd7, "r3_p1");
    checkOutput("r3_pcards", player_cards, 1);
    checkOutput("r3_pscore7", player_score, 7);
    drawCard(4'd10, "r3_d1");
    drawCard(4'd4,  "r3_p2");
    drawCard(4'd7,  "r3_d2");
    checkOutput("r3_pscore", player_score, 11);

    // Hit and stand together: stand wins, no card for the player.
    applyStimulus(1, 1, 0);
    checkOutput("r3_stand_wins", game_state, 7);
    checkOutput("r3_pcards_hold", player_cards, 2);
    waitState(4'd10, "r3_done_state");
    checkOutput("r3_result", result, 2);

    // Round 4: dealer A,6 soft 17 against player 18.
    applyStimulus(0, 0, 1);
    drawCard(4'd10, "r4_p1");
    drawCard(4'd1,  "r4_d1");
    drawCard(4'd8,  "r4_p2");
    drawCard(4'd6,  "r4_d2");
    checkOutput("r4_dscore", dealer_score, 17);
    applyStimulus(0, 1, 0);
    tick();
`ifdef DEALER_HIT_SOFT17_EN
    checkOutput("r4_soft_draw", game_state, 8);
    drawCard(4'd10, "r4_d3");
    waitState(4'd10, "r4_done_state");
    checkOutput("r4_dcards", dealer_cards, 3);
`else
    checkOutput("r4_soft_stand", game_state, 9);
    waitState(4'd10, "r4_done_state");
    checkOutput("r4_dcards", dealer_cards, 2);
`endif
    checkOutput("r4_result", result, 1);

    // Round 5: reset while the dealer is waiting on a card.
    applyStimulus(0, 0, 1);
    drawCard(4'd10, "r5_p1");
    drawCard(4'd2,  "r5_d1");
    drawCard(4'd7,  "r5_p2");
    drawCard(4'd3,  "r5_d2");
    applyStimulus(0, 1, 0);
    waitState(4'd8, "r5_ddraw");
    checkOutput("r5_req_before", card_req, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("r5_req", card_req, 0);
    checkOutput("r5_state", game_state, 0);
    checkOutput("r5_pscore", player_score, 0);
    checkOutput("r5_dscore", dealer_score, 0);
    checkOutput("r5_result", result, 0);
    card_ack  = 1'b1;
    card_rank = 4'd5;
    tick();
    card_ack  = 1'b0;
    tick();
    checkOutput("r5_late_ack_d", dealer_cards, 0);
    checkOutput("r5_late_ack_p", player_cards, 0);
    checkOutput("r5_late_state", game_state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
